bsg_fifo_1r1w_small_counted: RTL and testbench

Small 1-read/1-write FIFO built on a register array with asynchronous read. It adds an occupancy count, a programmable almost-full flag, a synchronous flush, and a controlled ready ramp after an asynchronous active-low reset. It is the drop-in successor for shallow decoupling buffers that need occupancy visibility, such as credit return, link back-pressure and debug counters.

---
 rtl/bsg_fifo_1r1w_small_counted_if.sv | 28 ++
 rtl/bsg_fifo_1r1w_small_counted.sv | 105 ++++++++++
 tb/tb_bsg_fifo_1r1w_small_counted.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bsg_fifo_1r1w_small_counted_if.sv
// Handshake bundle for bsg_fifo_1r1w_small_counted: enqueue/dequeue side, flush and occupancy.
// master = producer/consumer environment, slave = the FIFO.
interface bsg_fifo_1r1w_small_counted_if #(
    parameter int width_p = -1,
    parameter int els_p   = -1
);
    localparam int count_w = (els_p > 1) ? $clog2(els_p + 1) : 1;

    logic               flush_i;
    logic               v_i;
    logic               ready_o;
    logic [width_p-1:0] data_i;
    logic               v_o;
    logic [width_p-1:0] data_o;
    logic               yumi_i;
    logic [count_w-1:0] count_o;
    logic               almost_full_o;

    modport master (
        output flush_i, v_i, data_i, yumi_i,
        input  ready_o, v_o, data_o, count_o, almost_full_o
    );

    modport slave (
        input  flush_i, v_i, data_i, yumi_i,
        output ready_o, v_o, data_o, count_o, almost_full_o
    );
endinterface

// File: rtl/bsg_fifo_1r1w_small_counted.sv
// Small register-array FIFO with occupancy count, almost-full flag, flush and post-reset ready ramp.
// Define BSG_FIFO_1R1W_SMALL_COUNTED_BYPASS_EN for a zero-latency path through an empty FIFO.
module bsg_fifo_1r1w_small_counted #(
    parameter int width_p              = -1,
    parameter int els_p                = -1,
    parameter int ready_THEN_valid_p   = 0,
    parameter int almost_full_thresh_p = els_p - 1
) (
    input logic clk_i,
    input logic reset_n_i,
    bsg_fifo_1r1w_small_counted_if.slave fifo_if
);
    localparam int ptr_w     = (els_p > 2) ? $clog2(els_p) : 1;
    localparam int count_w   = (els_p > 1) ? $clog2(els_p + 1) : 1;
    localparam int mem_depth = (els_p > 1) ? els_p : 2;

    localparam logic [ptr_w-1:0]   last_ptr  = ptr_w'(els_p - 1);
    localparam logic [count_w-1:0] full_cnt  = count_w'(els_p);
    localparam logic [count_w-1:0] af_thresh = count_w'(almost_full_thresh_p);

    logic [width_p-1:0] mem_r [mem_depth];
    logic [ptr_w-1:0]   wptr_r, rptr_r;
    logic [count_w-1:0] count_r;
    logic               init_r;

    logic               full, empty, ready_int, v_int, enque, consumed;
    logic               do_enq, do_deq;
    logic [width_p-1:0] data_int;

    function automatic logic [ptr_w-1:0] ptr_inc(input logic [ptr_w-1:0] p);
        return (p == last_ptr) ? '0 : p + ptr_w'(1);
    endfunction

    always_comb begin
        full      = (count_r == full_cnt);
        empty     = (count_r == '0);
        ready_int = ~full & init_r & ~fifo_if.flush_i;
        enque     = (ready_THEN_valid_p != 0) ? fifo_if.v_i : (fifo_if.v_i & ready_int);
`ifdef BSG_FIFO_1R1W_SMALL_COUNTED_BYPASS_EN
        // An empty FIFO forwards the incoming item; if it is taken now it never touches storage.
        if (empty & ~fifo_if.flush_i) begin
            v_int    = fifo_if.v_i & ready_int;
            data_int = fifo_if.data_i;
            consumed = v_int & fifo_if.yumi_i;
        end else begin
            v_int    = ~empty & ~fifo_if.flush_i;
            data_int = mem_r[rptr_r];
            consumed = 1'b0;
        end
`else
        v_int    = ~empty & ~fifo_if.flush_i;
        data_int = mem_r[rptr_r];
        consumed = 1'b0;
`endif
        do_enq = enque & ~fifo_if.flush_i & ~consumed;
        do_deq = fifo_if.yumi_i & ~fifo_if.flush_i & ~consumed;
    end

    assign fifo_if.ready_o       = ready_int;
    assign fifo_if.v_o           = v_int;
    assign fifo_if.data_o        = data_int;
    assign fifo_if.count_o       = count_r;
    assign fifo_if.almost_full_o = (count_r >= af_thresh);

    always_ff @(posedge clk_i) begin
        if (do_enq) begin
            mem_r[wptr_r] <= fifo_if.data_i;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wptr_r  <= '0;
            rptr_r  <= '0;
            count_r <= '0;
            init_r  <= 1'b0;
        end else begin
            init_r <= 1'b1;
            if (fifo_if.flush_i) begin
                wptr_r  <= '0;
                rptr_r  <= '0;
                count_r <= '0;
            end else begin
                if (do_enq) wptr_r <= ptr_inc(wptr_r);
                if (do_deq) rptr_r <= ptr_inc(rptr_r);
                case ({do_enq, do_deq})
                    2'b10:   count_r <= count_r + count_w'(1);
                    2'b01:   count_r <= count_r - count_w'(1);
                    default: count_r <= count_r;
                endcase
            end
        end
    end

`ifndef SYNTHESIS
    // Flush overrides both handshakes, so strobes during flush are not protocol errors.
    assert property (@(posedge clk_i) disable iff (!reset_n_i)
        !(enque & full & ~fifo_if.flush_i))
        else $error("bsg_fifo_1r1w_small_counted: enqueue while full");

    assert property (@(posedge clk_i) disable iff (!reset_n_i)
        !(fifo_if.yumi_i & ~v_int & ~fifo_if.flush_i))
        else $error("bsg_fifo_1r1w_small_counted: yumi_i while v_o=0");
`endif
endmodule

// File: tb/tb_bsg_fifo_1r1w_small_counted.sv
// Directed self-checking bench for bsg_fifo_1r1w_small_counted (els_p=5, almost-full at 4).
// Expectations follow BSG_FIFO_1R1W_SMALL_COUNTED_BYPASS_EN when it is defined.
module tb_bsg_fifo_1r1w_small_counted;
    localparam int width_lp = 8;
    localparam int els_lp   = 5;

    logic clk_i;
    logic reset_n_i;
    int   errors;
    int   checks;

    bsg_fifo_1r1w_small_counted_if #(.width_p(width_lp), .els_p(els_lp)) bus ();

    bsg_fifo_1r1w_small_counted #(
        .width_p             (width_lp),
        .els_p               (els_lp),
        .ready_THEN_valid_p  (0),
        .almost_full_thresh_p(4)
    ) dut (
        .clk_i    (clk_i),
        .reset_n_i(reset_n_i),
        .fifo_if  (bus)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        reset_n_i   = 1'b0;
        bus.flush_i = 1'b0;
        bus.v_i     = 1'b0;
        bus.data_i  = '0;
        bus.yumi_i  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            checks++;
            if (bus.ready_o !== 1'b0 || bus.v_o !== 1'b0 || bus.count_o !== 3'd0) begin
                errors++;
                $display("[TB] FAIL reset_hold: ready=%b v=%b count=%0d, want 0 0 0", bus.ready_o, bus.v_o, bus.count_o);
            end
        end
        step();
        reset_n_i = 1'b1;
        @(negedge clk_i);
        checks++;
        if (bus.ready_o !== 1'b0 || bus.v_o !== 1'b0 || bus.count_o !== 3'd0) begin
            errors++;
            $display("[TB] FAIL reset_first_cycle: ready=%b v=%b count=%0d, want 0 0 0", bus.ready_o, bus.v_o, bus.count_o);
        end
        step();
        @(negedge clk_i);
        checks++;
        if (bus.ready_o !== 1'b1 || bus.v_o !== 1'b0 || bus.count_o !== 3'd0) begin
            errors++;
            $display("[TB] FAIL reset_ramp: ready=%b v=%b count=%0d, want 1 0 0", bus.ready_o, bus.v_o, bus.count_o);
        end
        step();
    endtask

    task automatic test_fill_drain();
        logic [7:0] exp_data;
        for (int i = 0; i < 5; i++) begin
            exp_data   = 8'((i + 1) * 8'h11);
            bus.v_i    = 1'b1;
            bus.data_i = exp_data;
            @(negedge clk_i);
            checks++;
            if (bus.ready_o !== 1'b1 || bus.count_o !== 3'(i) || bus.almost_full_o !== (i >= 4)) begin
                errors++;
                $display("[TB] FAIL fill_%0d: ready=%b count=%0d af=%b, want 1 %0d %b",
                         i, bus.ready_o, bus.count_o, bus.almost_full_o, i, (i >= 4));
            end
            step();
        end
        bus.v_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if (bus.count_o !== 3'd5 || bus.ready_o !== 1'b0 || bus.almost_full_o !== 1'b1 ||
            bus.v_o !== 1'b1 || bus.data_o !== 8'h11) begin
            errors++;
            $display("[TB] FAIL full_state: count=%0d ready=%b af=%b v=%b data=%h, want 5 0 1 1 11",
                     bus.count_o, bus.ready_o, bus.almost_full_o, bus.v_o, bus.data_o);
        end
        step();
        for (int i = 0; i < 5; i++) begin
            exp_data   = 8'((i + 1) * 8'h11);
            bus.yumi_i = 1'b1;
            @(negedge clk_i);
            checks++;
            if (bus.v_o !== 1'b1 || bus.data_o !== exp_data || bus.count_o !== 3'(5 - i) ||
                bus.almost_full_o !== ((5 - i) >= 4)) begin
                errors++;
                $display("[TB] FAIL drain_%0d: v=%b data=%h count=%0d af=%b, want 1 %h %0d %b",
                         i, bus.v_o, bus.data_o, bus.count_o, bus.almost_full_o, exp_data, 5 - i, ((5 - i) >= 4));
            end
            step();
        end
        bus.yumi_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if (bus.v_o !== 1'b0 || bus.count_o !== 3'd0 || bus.ready_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL drained: v=%b count=%0d ready=%b, want 0 0 1", bus.v_o, bus.count_o, bus.ready_o);
        end
        step();
    endtask

    task automatic test_wrap();
        for (int k = 0; k < 2; k++) begin
            bus.v_i    = 1'b1;
            bus.data_i = 8'(8'h60 + k);
            step();
        end
        for (int j = 0; j < 20; j++) begin
            bus.v_i    = 1'b1;
            bus.data_i = 8'(8'h62 + j);
            bus.yumi_i = 1'b1;
            @(negedge clk_i);
            checks++;
            if (bus.count_o !== 3'd2 || bus.data_o !== 8'(8'h60 + j) || bus.v_o !== 1'b1) begin
                errors++;
                $display("[TB] FAIL wrap_%0d: count=%0d data=%h v=%b, want 2 %h 1",
                         j, bus.count_o, bus.data_o, bus.v_o, 8'(8'h60 + j));
            end
            step();
        end
        bus.v_i = 1'b0;
        for (int j = 20; j < 22; j++) begin
            bus.yumi_i = 1'b1;
            @(negedge clk_i);
            checks++;
            if (bus.data_o !== 8'(8'h60 + j) || bus.count_o !== 3'(22 - j)) begin
                errors++;
                $display("[TB] FAIL wrap_tail_%0d: data=%h count=%0d, want %h %0d",
                         j, bus.data_o, bus.count_o, 8'(8'h60 + j), 22 - j);
            end
            step();
        end
        bus.yumi_i = 1'b0;
    endtask

    task automatic test_flush();
        for (int k = 0; k < 3; k++) begin
            bus.v_i    = 1'b1;
            bus.data_i = 8'(8'hA1 + k);
            step();
        end
        bus.v_i     = 1'b1;
        bus.data_i  = 8'hEE;
        bus.yumi_i  = 1'b1;
        bus.flush_i = 1'b1;
        @(negedge clk_i);
        checks++;
        if (bus.ready_o !== 1'b0 || bus.v_o !== 1'b0 || bus.count_o !== 3'd3) begin
            errors++;
            $display("[TB] FAIL flush_cycle: ready=%b v=%b count=%0d, want 0 0 3", bus.ready_o, bus.v_o, bus.count_o);
        end
        step();
        bus.yumi_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if (bus.ready_o !== 1'b0 || bus.v_o !== 1'b0 || bus.count_o !== 3'd0) begin
            errors++;
            $display("[TB] FAIL flush_hold: ready=%b v=%b count=%0d, want 0 0 0", bus.ready_o, bus.v_o, bus.count_o);
        end
        step();
        bus.flush_i = 1'b0;
        bus.v_i     = 1'b0;
        @(negedge clk_i);
        checks++;
        if (bus.count_o !== 3'd0 || bus.v_o !== 1'b0 || bus.ready_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL flush_after: count=%0d v=%b ready=%b, want 0 0 1", bus.count_o, bus.v_o, bus.ready_o);
        end
        bus.v_i    = 1'b1;
        bus.data_i = 8'h77;
        step();
        bus.v_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if (bus.count_o !== 3'd1 || bus.data_o !== 8'h77 || bus.v_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL flush_reuse: count=%0d data=%h v=%b, want 1 77 1", bus.count_o, bus.data_o, bus.v_o);
        end
        bus.yumi_i = 1'b1;
        step();
        bus.yumi_i = 1'b0;
    endtask

    task automatic test_bypass();
        bus.v_i    = 1'b1;
        bus.data_i = 8'hA5;
`ifdef BSG_FIFO_1R1W_SMALL_COUNTED_BYPASS_EN
        bus.yumi_i = 1'b1;
        @(negedge clk_i);
        checks++;
        if (bus.v_o !== 1'b1 || bus.data_o !== 8'hA5 || bus.count_o !== 3'd0) begin
            errors++;
            $display("[TB] FAIL bypass_same: v=%b data=%h count=%0d, want 1 a5 0", bus.v_o, bus.data_o, bus.count_o);
        end
        step();
        bus.v_i    = 1'b0;
        bus.yumi_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if (bus.v_o !== 1'b0 || bus.count_o !== 3'd0) begin
            errors++;
            $display("[TB] FAIL bypass_next: v=%b count=%0d, want 0 0", bus.v_o, bus.count_o);
        end
        step();
`else
        bus.yumi_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if (bus.v_o !== 1'b0 || bus.count_o !== 3'd0) begin
            errors++;
            $display("[TB] FAIL nobypass_same: v=%b count=%0d, want 0 0", bus.v_o, bus.count_o);
        end
        step();
        bus.v_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if (bus.v_o !== 1'b1 || bus.data_o !== 8'hA5 || bus.count_o !== 3'd1) begin
            errors++;
            $display("[TB] FAIL nobypass_next: v=%b data=%h count=%0d, want 1 a5 1", bus.v_o, bus.data_o, bus.count_o);
        end
        bus.yumi_i = 1'b1;
        step();
        bus.yumi_i = 1'b0;
`endif
    endtask

    task automatic test_mid_reset();
        for (int k = 0; k < 4; k++) begin
            bus.v_i    = 1'b1;
            bus.data_i = 8'(8'hB1 + k);
            step();
        end
        bus.v_i = 1'b0;
        #2;
        reset_n_i = 1'b0;
        #1;
        checks++;
        if (bus.count_o !== 3'd0 || bus.v_o !== 1'b0 || bus.ready_o !== 1'b0 || bus.almost_full_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_reset: count=%0d v=%b ready=%b af=%b, want 0 0 0 0",
                     bus.count_o, bus.v_o, bus.ready_o, bus.almost_full_o);
        end
        step();
        reset_n_i = 1'b1;
        @(negedge clk_i);
        checks++;
        if (bus.ready_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_reset_ramp0: ready=%b, want 0", bus.ready_o);
        end
        step();
        @(negedge clk_i);
        checks++;
        if (bus.ready_o !== 1'b1 || bus.v_o !== 1'b0 || bus.count_o !== 3'd0) begin
            errors++;
            $display("[TB] FAIL mid_reset_ramp1: ready=%b v=%b count=%0d, want 1 0 0", bus.ready_o, bus.v_o, bus.count_o);
        end
        step();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_fill_drain();
        test_wrap();
        test_flush();
        test_bypass();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("[TB] FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
